// File: rtl/aes_pkg.sv
// Shared types and constants for the AES stream loader: FSM states, key-size codes
// and the per-key-size byte counts.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_DATA,
        ST_LAUNCH,
        ST_WAIT
    } state_e;

    localparam logic [1:0] KS_128 = 2'b00;
    localparam logic [1:0] KS_192 = 2'b01;
    localparam logic [1:0] KS_256 = 2'b10;

    localparam logic [5:0] KEY_BYTES_128 = 6'd16;
    localparam logic [5:0] KEY_BYTES_192 = 6'd24;
    localparam logic [5:0] KEY_BYTES_256 = 6'd32;

    // Both 10 and 11 select the 256-bit key.
    function automatic logic [1:0] key_code(input logic [1:0] sel);
        return (sel == KS_128) ? KS_128 : ((sel == KS_192) ? KS_192 : KS_256);
    endfunction

    function automatic logic [5:0] key_bytes(input logic [1:0] code);
        case (code)
            KS_128:  return KEY_BYTES_128;
            KS_192:  return KEY_BYTES_192;
            default: return KEY_BYTES_256;
        endcase
    endfunction

endpackage

// File: rtl/aes_byte_shifter.sv
// Left-shifting register with byte insert at the LSB end; clr zeroes the register and,
// together with en, leaves only the new byte in the low bits.
module aes_byte_shifter #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [7:0]       in_byte,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        shift_d = clr ? '0 : shift_q;
        if (en) begin
            shift_d = {shift_d[WIDTH-9:0], in_byte};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
        end else if (clr || en) begin
            shift_q <= shift_d;
        end
    end

    assign q = shift_q;

endmodule

// File: rtl/aes_stream_loader.sv
// Byte-stream frame loader for the AES core: key (16/24/32 bytes) then one 128-bit block,
// followed by a start pulse and a wait for core_done. Optional macro AES_LOADER_KEY_REUSE_EN
// adds key_keep so a frame may reuse the previously loaded key.
module aes_stream_loader
    import aes_pkg::*;
#(
    parameter int DATA_BYTES = 16,
    parameter int KEY_MAX    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              sel,
    input  logic [7:0]              in_byte,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [KEY_MAX*8-1:0]    key_out,
    output logic [DATA_BYTES*8-1:0] data_out,
    output logic [1:0]              key_mode,
    output logic                    start,
    output logic                    busy,
    input  logic                    core_done
`ifdef AES_LOADER_KEY_REUSE_EN
    ,
    input  logic                    key_keep
`endif
);

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [1:0] key_mode_q, key_mode_d;
    logic       key_clr, key_en, data_en;
    logic       key_done;
    logic       reuse;
    logic       xfer;

    assign xfer = in_valid && in_ready;

`ifdef AES_LOADER_KEY_REUSE_EN
    logic key_loaded_q;

    // Reuse is only legal once some key has been fully loaded since reset.
    assign reuse = key_keep && key_loaded_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_loaded_q <= 1'b0;
        end else if (key_done) begin
            key_loaded_q <= 1'b1;
        end
    end
`else
    assign reuse = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_mode_d = key_mode_q;
        key_clr    = 1'b0;
        key_en     = 1'b0;
        data_en    = 1'b0;
        key_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    cnt_d = 6'd1;
                    if (reuse) begin
                        data_en = 1'b1;
                        state_d = ST_DATA;
                    end else begin
                        key_mode_d = key_code(sel);
                        key_clr    = 1'b1;
                        key_en     = 1'b1;
                        state_d    = ST_KEY;
                    end
                end
            end
            ST_KEY: begin
                if (xfer) begin
                    key_en = 1'b1;
                    if (cnt_q + 6'd1 == key_bytes(key_mode_q)) begin
                        key_done = 1'b1;
                        cnt_d    = 6'd0;
                        state_d  = ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    data_en = 1'b1;
                    if (cnt_q + 6'd1 == 6'(DATA_BYTES)) begin
                        cnt_d   = 6'd0;
                        state_d = ST_LAUNCH;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            key_mode_q <= KS_128;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_mode_q <= key_mode_d;
        end
    end

    aes_byte_shifter #(.WIDTH(KEY_MAX*8)) u_key_shift (
        .clk     (clk),
        .rst     (rst),
        .clr     (key_clr),
        .en      (key_en),
        .in_byte (in_byte),
        .q       (key_out)
    );

    aes_byte_shifter #(.WIDTH(DATA_BYTES*8)) u_data_shift (
        .clk     (clk),
        .rst     (rst),
        .clr     (1'b0),
        .en      (data_en),
        .in_byte (in_byte),
        .q       (data_out)
    );

    // Ready depends only on state and reset, never on in_valid.
    assign in_ready = rst && (state_q == ST_IDLE || state_q == ST_KEY || state_q == ST_DATA);
    assign start    = (state_q == ST_LAUNCH);
    assign busy     = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
    assign key_mode = key_mode_q;

endmodule

// File: tb/tb_aes_stream_loader.sv
// Self-checking bench for aes_stream_loader: directed frames with optional random stalls,
// sel toggling and stray core_done, compared against a byte-list model of the frame.
module tb_aes_stream_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   sel;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] key_out;
    logic [127:0] data_out;
    logic [1:0]   key_mode;
    logic         start;
    logic         busy;
    logic         core_done;
`ifdef AES_LOADER_KEY_REUSE_EN
    logic         key_keep;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]   key_bytes_q[$];
    logic [7:0]   data_bytes_q[$];
    logic [255:0] exp_key  = '0;
    logic [127:0] exp_data = '0;
    logic [1:0]   exp_mode = 2'b00;

    always #5 clk = ~clk;

    aes_stream_loader dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_out   (key_out),
        .data_out  (data_out),
        .key_mode  (key_mode),
        .start     (start),
        .busy      (busy),
        .core_done (core_done)
`ifdef AES_LOADER_KEY_REUSE_EN
        ,
        .key_keep  (key_keep)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Presents one byte, optionally after random idle cycles, and returns at the negedge
    // following its transfer.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit first);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                if (!first) begin
                    core_done = 1'($urandom);
                    sel       = 2'($urandom);
                end
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_byte  = b;
        if (gaps && !first) sel = 2'($urandom);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", {255'd0, in_ready}, 256'd1);
        @(negedge clk);
    endtask

    task automatic run_frame(input string name, input logic [1:0] fsel, input bit gaps,
                             input bit keep);
        logic [7:0] stream[$];
        $display("frame %s sel=%b gaps=%0d keep=%0d", name, fsel, gaps, keep);
        if (keep) begin
            stream = data_bytes_q;
        end else begin
            stream = {key_bytes_q, data_bytes_q};
            exp_key = '0;
            foreach (key_bytes_q[i]) exp_key = {exp_key[247:0], key_bytes_q[i]};
            exp_mode = (fsel == 2'b11) ? 2'b10 : fsel;
        end
        foreach (data_bytes_q[i]) exp_data = {exp_data[119:0], data_bytes_q[i]};
`ifdef AES_LOADER_KEY_REUSE_EN
        key_keep = keep;
`endif
        sel = fsel;
        foreach (stream[i]) begin
            if (i == stream.size() - 1) chk({name, "_nostart_early"}, {255'd0, start}, 256'd0);
            send_byte(stream[i], gaps, i == 0);
        end
        in_valid  = 1'b0;
        core_done = 1'b0;
`ifdef AES_LOADER_KEY_REUSE_EN
        key_keep = 1'b0;
`endif
        chk({name, "_start"},    {255'd0, start},    256'd1);
        chk({name, "_busy_l"},   {255'd0, busy},     256'd1);
        chk({name, "_ready_l"},  {255'd0, in_ready}, 256'd0);
        chk({name, "_key"},      key_out,            exp_key);
        chk({name, "_data"},     {128'd0, data_out}, {128'd0, exp_data});
        chk({name, "_mode"},     {254'd0, key_mode}, {254'd0, exp_mode});
        @(negedge clk);
        chk({name, "_start_off"}, {255'd0, start}, 256'd0);
        chk({name, "_busy_w"},    {255'd0, busy},  256'd1);
        // Offer bytes while waiting: none may be consumed.
        in_valid = 1'b1;
        repeat (4) begin
            in_byte = 8'($urandom);
            chk({name, "_ready_w"}, {255'd0, in_ready}, 256'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        chk({name, "_key_hold"},  key_out,            exp_key);
        chk({name, "_data_hold"}, {128'd0, data_out}, {128'd0, exp_data});
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk({name, "_busy_done"},  {255'd0, busy},     256'd0);
        chk({name, "_ready_done"}, {255'd0, in_ready}, 256'd1);
        chk({name, "_key_after"},  key_out,            exp_key);
    endtask

    task automatic fill_keys(input int n);
        key_bytes_q.delete();
        for (int i = 0; i < n; i++) key_bytes_q.push_back(8'(i));
    endtask

    task automatic fill_data(input bit descending);
        data_bytes_q.delete();
        for (int i = 0; i < 16; i++)
            data_bytes_q.push_back(descending ? 8'(8'hff - 8'(i * 17)) : 8'(i * 17));
    endtask

    initial begin
        rst       = 1'b0;
        sel       = 2'b00;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        core_done = 1'b0;
`ifdef AES_LOADER_KEY_REUSE_EN
        key_keep  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        chk("rst_key",   key_out,             256'd0);
        chk("rst_data",  {128'd0, data_out},  256'd0);
        chk("rst_mode",  {254'd0, key_mode},  256'd0);
        chk("rst_start", {255'd0, start},     256'd0);
        chk("rst_busy",  {255'd0, busy},      256'd0);
        chk("rst_ready", {255'd0, in_ready},  256'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rel_ready", {255'd0, in_ready}, 256'd1);
        @(negedge clk);

        fill_keys(16); fill_data(1'b0);
        run_frame("t1_k128", 2'b00, 1'b0, 1'b0);
        fill_keys(24); fill_data(1'b0);
        run_frame("t2_k192", 2'b01, 1'b0, 1'b0);
        fill_keys(32); fill_data(1'b0);
        run_frame("t3_k256", 2'b11, 1'b0, 1'b0);
        fill_keys(16); fill_data(1'b0);
        run_frame("t4_gaps", 2'b00, 1'b1, 1'b0);
        fill_keys(32); fill_data(1'b1);
        run_frame("t4_gaps256", 2'b10, 1'b1, 1'b0);

        // Abort mid-key with reset.
        $display("frame t5_abort sel=00 reset after 10 key bytes");
        sel = 2'b00;
        for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i), 1'b0, i == 0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("t5_key0",   key_out,            256'd0);
        chk("t5_data0",  {128'd0, data_out}, 256'd0);
        chk("t5_mode0",  {254'd0, key_mode}, 256'd0);
        chk("t5_busy0",  {255'd0, busy},     256'd0);
        chk("t5_ready0", {255'd0, in_ready}, 256'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fill_keys(16); fill_data(1'b0);
        run_frame("t5_reload", 2'b00, 1'b0, 1'b0);

`ifdef AES_LOADER_KEY_REUSE_EN
        fill_keys(16); fill_data(1'b0);
        run_frame("t6_load", 2'b00, 1'b0, 1'b0);
        fill_data(1'b1);
        run_frame("t6_reuse", 2'b01, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
